pc_unit: RTL
============

Name: pc_unit

Overview:
- Program-counter and next-PC stage. It sits directly upstream of the instruction decoder and feeds the instruction memory address.
- It consumes the decoder's nPC_sel code, together with the ALU zero flag and the instruction fields, and registers the next PC each cycle.
- It provides a STOP halt state with resume, a hazard stall hold, the link value for jal, and a retired-instruction counter.
- The PC is word-addressed: sequential flow is PC+1.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- nPC_sel  input  3  next-PC code from decoder: 000 seq, 001 beq, 010 bne, 011 j, 100 jal, 101 jr, 110 stop, 111 reserved.
- zero  input  1  ALU zero flag for the current instruction.
- imm16  input  16  instruction[15:0], branch offset in words.
- target26  input  26  instruction[25:0], jump index.
- jr_target  input  32  register value rs, the ALU pass-A result.
- stall  input  1  hazard hold; the PC does not advance.
- resume  input  1  leave the halt state.
- pc  output  32  current PC, registered; drives the instruction memory address.
- pc_plus1  output  32  pc+1, combinational; jal link value.
- halted  output  1  1 while in HALT, registered.
- retired  output  CNT_W  count of instructions that advanced the PC, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=RUN, halted=0, retired=0. All are held while rst_n=0.
- First PC update occurs on the first rising clk edge after rst_n deasserts.
- States: RUN, HALT. halted equals (state==HALT).

Next-PC computation (combinational, all arithmetic mod 2^32):
- seq = pc+1.
- br = pc+1+sext32(imm16).
- jmp = {pc_plus1[31:26], target26}.
- jr = jr_target.

nPC mapping in RUN:
- 000 → seq.
- 001 → br if zero=1, else seq.
- 010 → br if zero=0, else seq.
- 011 → jmp.
- 100 → jmp. The link value is pc_plus1, written elsewhere the same cycle.
- 101 → jr.
- 110 → pc unchanged, and next state HALT.
- 111 → seq; reserved code, treated as sequential.

RUN, per rising edge:
- stall=1: pc, state and retired are all held. nPC_sel is ignored, including 110.
- stall=0: pc ← mapped value and retired ← retired+1. This includes the stop instruction, which counts once.
- 110 with stall=0: state ← HALT.

HALT, per rising edge:
- pc is held at the stop instruction address and nPC_sel is ignored. The stop opcode stays fetched, so 110 re-presents every cycle.
- resume=1 and stall=0: pc ← pc+1, state ← RUN, retired unchanged.
- resume=1 and stall=1: stay in HALT; stall wins.
- resume in RUN: ignored.

Latency and boundaries:
- A taken branch or jump is visible on pc one cycle after its instruction is presented. There are no delay slots.
- Counter wraps from 2^CNT_W-1 to 0 without any flag.
- PC wraps from 32'hFFFF_FFFF to 0 on seq.
- Negative imm16 branches backward. imm16=16'hFFFF targets the branch itself: a self-loop where pc stays constant but retired increments.
- Reset asserted mid-stall or in HALT returns immediately to reset values, regardless of clk.

Test Plan:
- Reset/seq: rst_n low 3 cycles, then release with nPC_sel=000, stall=0 → pc 0,1,2,3 on successive edges; retired 0,1,2,3; halted=0.
- beq/bne: at pc=10, imm16=16'h0005. nPC_sel=001, zero=1 → pc=16. Repeat at pc=16 with zero=0 → pc=17. nPC_sel=010, zero=0, imm16=16'hFFFC → pc=14.
- j/jal/jr: pc=32'h1400_0003, target26=26'h000_0040, nPC_sel=100 → pc_plus1=32'h1400_0004 before the edge, pc=32'h1400_0040 after. Then nPC_sel=101, jr_target=32'h0000_0123 → pc=32'h123.
- Stall: stall=1 for 4 cycles at pc=7 with nPC_sel=011 → pc=7 and retired frozen. Release stall → jump taken on the next edge; retired +1.
- Halt/resume: nPC_sel=110 at pc=20 → halted=1, pc stays 20 for 10 cycles, retired +1 only once. resume with stall=1 → still halted. resume with stall=0 → pc=21, halted=0.
- Async reset mid-halt: drop rst_n between clock edges while halted=1 with retired=50 → pc=RESET_PC, halted=0, retired=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter and next-PC stage: selects the next word address from the
// decoder's nPC_sel code, holds on stall, halts on stop and counts retired instructions.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       nPC_sel,
  input  logic             zero,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [31:0]      jr_target,
  input  logic             stall,
  input  logic             resume,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus1,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic [31:0]      pc_reg;
  logic             halted_reg;
  logic [CNT_W-1:0] retired_reg;

  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] mapped_next;

  assign pc_plus1   = pc_reg + 32'd1;
  assign br_target  = pc_plus1 + {{16{imm16[15]}}, imm16};
  assign jmp_target = {pc_plus1[31:26], target26};

  always_comb begin
    mapped_next = pc_plus1;
    case (nPC_sel)
      3'b001:  mapped_next = zero ? br_target : pc_plus1;
      3'b010:  mapped_next = zero ? pc_plus1 : br_target;
      3'b011:  mapped_next = jmp_target;
      3'b100:  mapped_next = jmp_target;
      3'b101:  mapped_next = jr_target;
      3'b110:  mapped_next = pc_reg;
      default: mapped_next = pc_plus1;
    endcase
  end

  // In HALT the stop opcode keeps being presented, so nPC_sel is ignored there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      pc_reg      <= RESET_PC;
      halted_reg  <= 1'b0;
      retired_reg <= '0;
    end else if (!stall) begin
      case (state_reg)
        RUN: begin
          pc_reg      <= mapped_next;
          retired_reg <= retired_reg + CNT_ONE;
          if (nPC_sel == 3'b110) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end
        end
        HALT: begin
          if (resume) begin
            pc_reg     <= pc_plus1;
            state_reg  <= RUN;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= RUN;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pc      = pc_reg;
  assign halted  = halted_reg;
  assign retired = retired_reg;

endmodule
